// File: rtl/mtrx_addsub_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mtrx_addsub_engine
//  Purpose  : Element-wise signed matrix add/subtract, LANES elements per beat,
//             wrap or saturate per transaction, sticky overflow report.
//  Revision : 1.0  initial release
// ============================================================================
module mtrx_addsub_engine #(
    parameter int ELEM_W = 8,
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int LANES  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [ROWS*COLS*ELEM_W-1:0]   i_a,
    input  logic [ROWS*COLS*ELEM_W-1:0]   i_b,
    input  logic                          i_op,
    input  logic                          i_sat,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [ROWS*COLS*ELEM_W-1:0]   o_c,
    output logic                          o_overflow
);

    localparam int N     = ROWS * COLS;
    localparam int NW    = N * ELEM_W;
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ELEM_W-1:0] C_MAX     = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] C_MIN     = {1'b1, {(ELEM_W-1){1'b0}}};

    // Reject geometries the beat schedule cannot cover exactly.
    if ((N % LANES) != 0) begin : g_lanes_check
        $error("mtrx_addsub_engine: ROWS*COLS must be a multiple of LANES");
    end
    if (ELEM_W < 2) begin : g_width_check
        $error("mtrx_addsub_engine: ELEM_W must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_beat;
    logic [NW-1:0]   r_a;
    logic [NW-1:0]   r_b;
    logic            r_op;
    logic            r_sat;
    logic [NW-1:0]   r_c;
    logic            r_overflow;
    logic            r_out_valid;

    int                 w_base;
    logic [ELEM_W-1:0]  w_res [LANES];
    logic [LANES-1:0]   w_ovf;
    logic               w_accept;

    // First element index handled by the current beat.
    always_comb begin
        w_base = int'(r_beat) * LANES;
    end

    // One exact (ELEM_W+1)-bit adder/subtractor per lane on the captured operands.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [ELEM_W-1:0]   w_ae;
        logic [ELEM_W-1:0]   w_be;
        logic [ELEM_W:0]     w_ea;
        logic [ELEM_W:0]     w_eb;
        logic [ELEM_W:0]     w_sum;

        assign w_ae  = r_a[(w_base + j) * ELEM_W +: ELEM_W];
        assign w_be  = r_b[(w_base + j) * ELEM_W +: ELEM_W];
        assign w_ea  = {w_ae[ELEM_W-1], w_ae};
        assign w_eb  = {w_be[ELEM_W-1], w_be};
        assign w_sum = r_op ? (w_ea + w_eb) : (w_ea - w_eb);
        // Exact result fits only when the two top bits agree.
        assign w_ovf[j] = w_sum[ELEM_W] ^ w_sum[ELEM_W-1];
        // Clamp direction follows the sign of the exact result.
        assign w_res[j] = (w_ovf[j] && r_sat) ? (w_sum[ELEM_W] ? C_MIN : C_MAX)
                                              : w_sum[ELEM_W-1:0];
    end

    // Ready whenever idle, or when the pending result is being drained this edge.
    always_comb begin
        o_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
        w_accept   = i_in_valid && o_in_ready;
    end

    // Control FSM plus operand capture and beat-wise result accumulation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_sat       <= 1'b0;
            r_c         <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= i_a;
                        r_b        <= i_b;
                        r_op       <= i_op;
                        r_sat      <= i_sat;
                        r_beat     <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_c[(w_base + j) * ELEM_W +: ELEM_W] <= w_res[j];
                    end
                    r_overflow <= r_overflow | (|w_ovf);
                    if (r_beat == LAST_BEAT) begin
                        r_beat      <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (i_in_valid) begin
                            r_a        <= i_a;
                            r_b        <= i_b;
                            r_op       <= i_op;
                            r_sat      <= i_sat;
                            r_beat     <= '0;
                            r_overflow <= 1'b0;
                            r_state    <= S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_c         = r_c;
    assign o_overflow  = r_overflow;
    assign o_out_valid = r_out_valid;

endmodule
`default_nettype wire
